// File: rtl/uart_boot_ctrl.sv
// UART boot loader: receives a 16-bit word count and a little-endian word image, then writes it to memory.
// Defining BOOT_CHECKSUM_EN adds a trailing XOR checksum byte that selects DONE or ERR.
module uart_boot_ctrl #(
  parameter int ADDR_W = 16,
  parameter int BASE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_i_boot,
  input  logic              io_i_rx_valid,
  input  logic [7:0]        io_i_rx_data,
  output logic              io_o_rx_ready,
  output logic              io_o_mem_valid,
  output logic [ADDR_W-1:0] io_o_mem_addr,
  output logic [31:0]       io_o_mem_wdata,
  input  logic              io_i_mem_ready,
  output logic              io_o_core_rst,
  output logic              io_o_done,
  output logic              io_o_err
);

  // state | meaning
  // IDLE  | one cycle after reset; samples the boot strap
  // LEN0  | waiting for word count low byte
  // LEN1  | waiting for word count high byte
  // DATA  | collecting the four bytes of the current word
  // WRITE | presenting the assembled word to memory until accepted
  // CHK   | waiting for the checksum byte (checksum build only)
  // DONE  | image loaded, core released; terminal
  // ERR   | checksum mismatch, core held; terminal
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              w_chk;
  logic              w_rx_acc;
  logic              w_wr_acc;
  logic [15:0]       w_len_full;
  logic              w_last_word;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        r_csum;
  assign w_chk = (r_state == S_CHK);
`else
  assign w_chk = 1'b0;
`endif

  assign io_o_rx_ready  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                          (r_state == S_DATA) || w_chk;
  assign io_o_mem_valid = (r_state == S_WRITE);
  assign io_o_mem_addr  = r_addr;
  assign io_o_mem_wdata = r_wdata;
  assign io_o_core_rst  = (r_state != S_DONE);
  assign io_o_done      = (r_state == S_DONE);
`ifdef BOOT_CHECKSUM_EN
  assign io_o_err       = (r_state == S_ERR);
`else
  assign io_o_err       = 1'b0;
`endif

  assign w_rx_acc    = io_o_rx_ready && io_i_rx_valid;
  assign w_wr_acc    = io_o_mem_valid && io_i_mem_ready;
  assign w_len_full  = {io_i_rx_data, r_len[7:0]};
  // r_len counts down remaining words, so the last write is the one seen with a count of 1
  assign w_last_word = (r_len == 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = io_i_boot ? S_LEN0 : S_DONE;
      S_LEN0:  if (w_rx_acc) w_state_nxt = S_LEN1;
      S_LEN1:  if (w_rx_acc) w_state_nxt = (w_len_full == 16'd0) ? S_END : S_DATA;
      S_DATA:  if (w_rx_acc && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
      S_WRITE: if (w_wr_acc) w_state_nxt = w_last_word ? S_END : S_DATA;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:   if (w_rx_acc) w_state_nxt = (io_i_rx_data == r_csum) ? S_DONE : S_ERR;
`endif
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_len      <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_addr     <= BASE_A;
      r_wdata    <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      if (w_rx_acc) begin
        case (r_state)
          S_LEN0: r_len[7:0]  <= io_i_rx_data;
          S_LEN1: r_len[15:8] <= io_i_rx_data;
          S_DATA: begin
            r_wdata[{r_byte_cnt, 3'b000} +: 8] <= io_i_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            r_csum <= r_csum ^ io_i_rx_data;
`endif
          end
          default: ;
        endcase
      end
      if (w_wr_acc) begin
        r_len  <= r_len - 16'd1;
        r_addr <= r_addr + ADDR_W'(4);
      end
    end
  end

endmodule
